// File: rtl/hazard_scheduler_if.sv
// hazard_scheduler_if: bundle between the pipeline and the stall/flush scheduler.
//   master : pipeline side; drives hazard events, receives stall/flush/redirect
//            controls and the scheduler's status/performance outputs.
//   slave  : scheduler side.
// Events : ic_miss, dc_miss, br_resolve, br_mispredict, ex_is_load,
//          ex_uses_rw/ex_rw_addr, dec_uses_rs/dec_rs_addr, dec_uses_rt/dec_rt_addr
// Control: pc_stall, redirect, {i2d,d2e,e2m,m2w}_{stall,flush}
// Status : miss_timeout, stall_cycles, flush_count (CNT_W wide)
interface hazard_scheduler_if #(
  parameter int CNT_W = 32
);
  logic             ic_miss;
  logic             dc_miss;
  logic             br_resolve;
  logic             br_mispredict;
  logic             ex_is_load;
  logic             ex_uses_rw;
  logic [4:0]       ex_rw_addr;
  logic             dec_uses_rs;
  logic [4:0]       dec_rs_addr;
  logic             dec_uses_rt;
  logic [4:0]       dec_rt_addr;

  logic             pc_stall;
  logic             redirect;
  logic             i2d_stall, i2d_flush;
  logic             d2e_stall, d2e_flush;
  logic             e2m_stall, e2m_flush;
  logic             m2w_stall, m2w_flush;
  logic             miss_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output ic_miss, dc_miss, br_resolve, br_mispredict, ex_is_load,
           ex_uses_rw, ex_rw_addr, dec_uses_rs, dec_rs_addr, dec_uses_rt, dec_rt_addr,
    input  pc_stall, redirect, i2d_stall, i2d_flush, d2e_stall, d2e_flush,
           e2m_stall, e2m_flush, m2w_stall, m2w_flush,
           miss_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  ic_miss, dc_miss, br_resolve, br_mispredict, ex_is_load,
           ex_uses_rw, ex_rw_addr, dec_uses_rs, dec_rs_addr, dec_uses_rt, dec_rt_addr,
    output pc_stall, redirect, i2d_stall, i2d_flush, d2e_stall, d2e_flush,
           e2m_stall, e2m_flush, m2w_stall, m2w_flush,
           miss_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: central stall/flush scheduler for the 5-stage MIPS pipeline.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset; while low every pipeline register
//            is flushed and nothing stalls or redirects
//   hs     : hazard_scheduler_if.slave (events in, controls/status out)
// Controls are combinational from the inputs and registered state. Registered
// state: FSM (RUN/DMISS/DMISS_PEND), pending redirect, miss watchdog and
// saturating stall/redirect counters.
module hazard_scheduler #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_scheduler_if.slave hs
);

  localparam logic [1:0]  ST_RUN        = 2'd0;
  localparam logic [1:0]  ST_DMISS      = 2'd1;
  localparam logic [1:0]  ST_DMISS_PEND = 2'd2;
  localparam logic [15:0] TO_LAST       = 16'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic             pend_q, pend_d;
  logic [15:0]      miss_cnt_q, miss_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic mis_ev, mis, load_use;
  logic pc_stall, redirect;
  logic i2d_s, i2d_f, d2e_s, d2e_f, e2m_s, e2m_f, m2w_s, m2w_f;

  assign mis_ev = hs.br_resolve & hs.br_mispredict;
  // A mispredict captured under a miss is replayed once the miss releases.
  assign mis    = mis_ev | pend_q | (state_q == ST_DMISS_PEND);

  assign load_use = hs.ex_is_load & hs.ex_uses_rw & (|hs.ex_rw_addr) &
                    ((hs.dec_uses_rs & (hs.dec_rs_addr == hs.ex_rw_addr)) |
                     (hs.dec_uses_rt & (hs.dec_rt_addr == hs.ex_rw_addr)));

  // Stall and flush are never requested together on one register: a flush
  // under stall would be dropped by the pipeline register.
  always_comb begin
    pc_stall = 1'b0; redirect = 1'b0;
    i2d_s = 1'b0; i2d_f = 1'b0; d2e_s = 1'b0; d2e_f = 1'b0;
    e2m_s = 1'b0; e2m_f = 1'b0; m2w_s = 1'b0; m2w_f = 1'b0;
    if (!rst_n) begin
      i2d_f = 1'b1; d2e_f = 1'b1; e2m_f = 1'b1; m2w_f = 1'b1;
    end else if (hs.dc_miss) begin
      // Freeze IF..MEM; feed a bubble into WB so the stalled MEM result
      // is not written back twice.
      pc_stall = 1'b1; i2d_s = 1'b1; d2e_s = 1'b1; e2m_s = 1'b1;
      m2w_f    = 1'b1;
    end else if (mis) begin
      redirect = 1'b1; i2d_f = 1'b1; d2e_f = 1'b1;
    end else if (load_use) begin
      pc_stall = 1'b1; i2d_s = 1'b1; d2e_f = 1'b1;
    end else if (hs.ic_miss) begin
      pc_stall = 1'b1; i2d_f = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:        if (hs.dc_miss) state_d = mis_ev ? ST_DMISS_PEND : ST_DMISS;
      ST_DMISS:      if (!hs.dc_miss) state_d = ST_RUN;
                     else if (mis_ev) state_d = ST_DMISS_PEND;
      ST_DMISS_PEND: if (!hs.dc_miss) state_d = ST_RUN;
      default:       state_d = ST_RUN;
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    if (hs.dc_miss && mis_ev) pend_d = 1'b1;
    if (redirect)             pend_d = 1'b0;

    miss_cnt_d = 16'd0;
    if (hs.dc_miss)
      miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;

    timeout_d = timeout_q | (hs.dc_miss && (miss_cnt_q == TO_LAST));

    stall_d = stall_q;
    if (pc_stall && (stall_q != '1)) stall_d = stall_q + CNT_ONE;
    flush_d = flush_q;
    if (redirect && (flush_q != '1)) flush_d = flush_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pend_q     <= 1'b0;
      miss_cnt_q <= 16'd0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      miss_cnt_q <= miss_cnt_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign hs.pc_stall     = pc_stall;
  assign hs.redirect     = redirect;
  assign hs.i2d_stall    = i2d_s;
  assign hs.i2d_flush    = i2d_f;
  assign hs.d2e_stall    = d2e_s;
  assign hs.d2e_flush    = d2e_f;
  assign hs.e2m_stall    = e2m_s;
  assign hs.e2m_flush    = e2m_f;
  assign hs.m2w_stall    = m2w_s;
  assign hs.m2w_flush    = m2w_f;
  assign hs.miss_timeout = timeout_q;
  assign hs.stall_cycles = stall_q;
  assign hs.flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler: directed scoreboard bench for hazard_scheduler
// (TIMEOUT=4, CNT_W=4). Each driven cycle pushes its expected control vector
// {pc_stall, redirect, i2d_s, i2d_f, d2e_s, d2e_f, e2m_s, e2m_f, m2w_s, m2w_f};
// the vector is popped and compared on the following negedge.
module tb_hazard_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_scheduler_if #(.CNT_W(4)) hif ();
  hazard_scheduler #(.TIMEOUT(4), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .hs(hif));

  localparam logic [9:0] C_IDLE = 10'b0000000000;
  localparam logic [9:0] C_RST  = 10'b0001010101;
  localparam logic [9:0] C_LU   = 10'b1010010000;
  localparam logic [9:0] C_MP   = 10'b0101010000;
  localparam logic [9:0] C_IC   = 10'b1001000000;
  localparam logic [9:0] C_DM   = 10'b1010101001;

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] exp_q[$];
  logic [9:0] ctrl;

  assign ctrl = {hif.pc_stall, hif.redirect, hif.i2d_stall, hif.i2d_flush,
                 hif.d2e_stall, hif.d2e_flush, hif.e2m_stall, hif.e2m_flush,
                 hif.m2w_stall, hif.m2w_flush};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    hif.ic_miss = 0; hif.dc_miss = 0; hif.br_resolve = 0; hif.br_mispredict = 0;
    hif.ex_is_load = 0; hif.ex_uses_rw = 0; hif.ex_rw_addr = 0;
    hif.dec_uses_rs = 0; hif.dec_rs_addr = 0; hif.dec_uses_rt = 0; hif.dec_rt_addr = 0;
  endtask

  task automatic step(input string tag, input logic [9:0] e);
    logic [9:0] want;
    exp_q.push_back(e);
    @(negedge clk);
    want = exp_q.pop_front();
    chk(tag, {22'd0, ctrl}, {22'd0, want});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic set_lu(input logic [4:0] rw, input logic urs, input logic [4:0] rs,
                        input logic urt, input logic [4:0] rt, input logic ld);
    idle_in();
    hif.ex_is_load = ld; hif.ex_uses_rw = 1; hif.ex_rw_addr = rw;
    hif.dec_uses_rs = urs; hif.dec_rs_addr = rs;
    hif.dec_uses_rt = urt; hif.dec_rt_addr = rt;
  endtask

  initial begin
    idle_in();
    rst_n = 1'b0;
    #3;
    chk("rst_ctrl", {22'd0, ctrl}, {22'd0, C_RST});
    chk("rst_stall_cnt", {28'd0, hif.stall_cycles}, 32'd0);
    chk("rst_flush_cnt", {28'd0, hif.flush_count}, 32'd0);
    chk("rst_timeout", {31'd0, hif.miss_timeout}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("idle", C_IDLE);

    // load-use hazards
    set_lu(5'd8, 1, 5'd8, 0, 5'd0, 1);  step("lu_rs", C_LU);
    chk("lu_stall_cnt", {28'd0, hif.stall_cycles}, 32'd1);
    set_lu(5'd8, 1, 5'd3, 1, 5'd8, 1);  step("lu_rt", C_LU);
    set_lu(5'd0, 1, 5'd0, 1, 5'd0, 1);  step("lu_r0", C_IDLE);
    set_lu(5'd8, 0, 5'd8, 0, 5'd8, 1);  step("lu_nouse", C_IDLE);
    set_lu(5'd8, 1, 5'd8, 0, 5'd0, 0);  step("lu_noload", C_IDLE);
    chk("lu_stall_cnt2", {28'd0, hif.stall_cycles}, 32'd2);

    // mispredict without a miss beats ic_miss and load-use
    idle_in(); hif.ic_miss = 1; hif.br_resolve = 1; hif.br_mispredict = 1;
    step("mp_ic", C_MP);
    chk("mp_flush_cnt", {28'd0, hif.flush_count}, 32'd1);
    chk("mp_stall_cnt", {28'd0, hif.stall_cycles}, 32'd2);
    idle_in(); hif.ic_miss = 1; step("ic", C_IC);
    set_lu(5'd8, 1, 5'd8, 0, 5'd0, 1); hif.br_resolve = 1; hif.br_mispredict = 1;
    step("mp_lu", C_MP);
    idle_in(); step("idle2", C_IDLE);
    chk("mp_flush_cnt2", {28'd0, hif.flush_count}, 32'd2);

    // mispredict under a 10-cycle miss, extra pulse must not double-issue
    do_reset();
    for (int i = 0; i < 10; i++) begin
      idle_in(); hif.dc_miss = 1;
      if (i == 3 || i == 6) begin hif.br_resolve = 1; hif.br_mispredict = 1; end
      step("dmiss", C_DM);
    end
    idle_in(); step("dmiss_redir", C_MP);
    step("dmiss_after", C_IDLE);
    chk("dmiss_flush_cnt", {28'd0, hif.flush_count}, 32'd1);
    chk("dmiss_stall_cnt", {28'd0, hif.stall_cycles}, 32'd10);
    chk("dmiss_timeout", {31'd0, hif.miss_timeout}, 32'd1);

    // mispredict in the very cycle the miss begins
    do_reset();
    idle_in(); hif.dc_miss = 1; hif.br_resolve = 1; hif.br_mispredict = 1;
    step("same_miss0", C_DM);
    idle_in(); hif.dc_miss = 1; step("same_miss1", C_DM);
    idle_in(); step("same_redir", C_MP);
    step("same_after", C_IDLE);
    chk("same_flush_cnt", {28'd0, hif.flush_count}, 32'd1);

    // watchdog: 3-cycle miss stays clear, 6-cycle miss trips after 4th cycle
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle_in(); hif.dc_miss = 1; step("wd3", C_DM);
    end
    idle_in(); step("wd3_end", C_IDLE);
    chk("wd3_timeout", {31'd0, hif.miss_timeout}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      idle_in(); hif.dc_miss = 1; step("wd6", C_DM);
      chk("wd6_timeout", {31'd0, hif.miss_timeout}, (i >= 3) ? 32'd1 : 32'd0);
    end
    idle_in(); step("wd6_end", C_IDLE); step("wd6_end2", C_IDLE);
    chk("wd_sticky", {31'd0, hif.miss_timeout}, 32'd1);

    // stall counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) begin
      idle_in(); hif.ic_miss = 1; step("sat_ic", C_IC);
      if (i == 14) chk("sat_reach", {28'd0, hif.stall_cycles}, 32'd15);
    end
    chk("sat_hold", {28'd0, hif.stall_cycles}, 32'd15);

    // async reset mid-miss with a pending redirect
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle_in(); hif.dc_miss = 1;
      if (i == 2) begin hif.br_resolve = 1; hif.br_mispredict = 1; end
      step("ar_miss", C_DM);
    end
    idle_in(); hif.dc_miss = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ctrl", {22'd0, ctrl}, {22'd0, C_RST});
    chk("ar_stall_cnt", {28'd0, hif.stall_cycles}, 32'd0);
    chk("ar_flush_cnt", {28'd0, hif.flush_count}, 32'd0);
    chk("ar_timeout", {31'd0, hif.miss_timeout}, 32'd0);
    @(posedge clk); #1;
    chk("ar_hold_ctrl", {22'd0, ctrl}, {22'd0, C_RST});
    #2 rst_n = 1'b1;
    step("ar_post_miss0", C_DM);
    step("ar_post_miss1", C_DM);
    idle_in(); step("ar_no_redir", C_IDLE);
    chk("ar_flush_cnt2", {28'd0, hif.flush_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
